// File: rtl/div_seq_pkg.sv
// Shared definitions for the multi-cycle DIV/DIVU sequencer.
package div_seq_pkg;

  // Number of restoring iterations for a 32-bit divide
  localparam int DIV_CYCLES = 32;

  // ALU control codes that request a divide (drive start / signed_div)
  localparam logic [3:0] DIV_CONTROL  = 4'b1010;
  localparam logic [3:0] DIVU_CONTROL = 4'b1011;

  // Sequencer states
  typedef enum logic [1:0] {
    DIV_IDLE  = 2'd0,
    DIV_BUSY  = 2'd1,
    DIV_DZERO = 2'd2,
    DIV_DONE  = 2'd3
  } div_state_e;

endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift the next dividend bit into the partial
// remainder, trial-subtract the divisor, keep or restore, and shift the
// resulting quotient bit in from the LSB.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH:0]   rem_in,
  input  logic [WIDTH-1:0] quo_in,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH:0]   rem_out,
  output logic [WIDTH-1:0] quo_out
);

  // Two extra bits on the trial difference so its sign is unambiguous
  logic [WIDTH+1:0] shifted;
  logic [WIDTH+1:0] diff;

  // Trial subtract; a negative difference means restore (quotient bit 0)
  always_comb begin
    shifted = {rem_in, quo_in[WIDTH-1]};
    diff    = shifted - {2'b00, divisor};
    if (diff[WIDTH+1]) begin
      rem_out = shifted[WIDTH:0];
      quo_out = {quo_in[WIDTH-2:0], 1'b0};
    end else begin
      rem_out = diff[WIDTH:0];
      quo_out = {quo_in[WIDTH-2:0], 1'b1};
    end
  end

endmodule

// File: rtl/div_seq.sv
// Multi-cycle DIV/DIVU sequencer beside the EX-stage ALU. Latches operands
// on a start request, runs one restoring step per cycle, stalls the pipe
// while working and issues a single HI/LO write (HI=remainder, LO=quotient).
// annul aborts without writing; rst returns everything to zero.
module div_seq
  import div_seq_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             signed_div,
  input  logic [WIDTH-1:0] opa,
  input  logic [WIDTH-1:0] opb,
  input  logic             annul,
  output logic             stall,
  output logic             ready,
  output logic             hilo_we,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

  div_state_e       state;
  div_state_e       state_next;
  logic [CNT_W-1:0] count;

  // Working datapath: partial remainder (one guard bit), dividend/quotient
  // shift register, magnitude of divisor and the deferred sign corrections
  logic [WIDTH:0]   rem;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] divisor;
  logic             neg_q;
  logic             neg_r;

  logic [WIDTH:0]   step_rem;
  logic [WIDTH-1:0] step_quo;
  logic             accept;

  // Two's complement negate when requested; used both for taking operand
  // magnitudes and for restoring result signs. Wraps for the most negative
  // value, which gives 0x80000000 / -1 = 0x80000000 as required by MIPS.
  function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] v,
                                                input logic             neg);
    logic signed [WIDTH-1:0] sv;
    sv = signed'(v);
    return neg ? unsigned'(-sv) : v;
  endfunction

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_in  (rem),
    .quo_in  (quo),
    .divisor (divisor),
    .rem_out (step_rem),
    .quo_out (step_quo)
  );

  assign accept = (state == DIV_IDLE) && start && !annul;

  // Next state and handshake outputs; annul overrides everything
  always_comb begin
    state_next = state;
    stall      = 1'b0;
    ready      = 1'b0;
    hilo_we    = 1'b0;
    case (state)
      DIV_IDLE: begin
        if (start) begin
          state_next = (opb == '0) ? DIV_DZERO : DIV_BUSY;
          stall      = !annul;
        end
      end
      DIV_BUSY: begin
        stall = 1'b1;
        if (count == LAST_STEP) state_next = DIV_DONE;
      end
      DIV_DZERO: begin
        stall      = 1'b1;
        state_next = DIV_DONE;
      end
      DIV_DONE: begin
        // A start still held here belongs to the instruction now retiring
        ready      = !annul;
        hilo_we    = !annul;
        state_next = DIV_IDLE;
      end
      default: state_next = DIV_IDLE;
    endcase
    if (annul) state_next = DIV_IDLE;
  end

  // State register and iteration counter
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= DIV_IDLE;
      count <= '0;
    end else begin
      state <= state_next;
      if (state == DIV_BUSY && state_next == DIV_BUSY) count <= count + 1'b1;
      else count <= '0;
    end
  end

  // Result registers, loaded with sign fix-up only on the edge into DONE
  always_ff @(posedge clk) begin
    if (rst) begin
      hi_out <= '0;
      lo_out <= '0;
    end else if (state_next == DIV_DONE) begin
      if (state == DIV_DZERO) begin
        hi_out <= '0;
        lo_out <= '0;
      end else begin
        hi_out <= cond_neg(step_rem[WIDTH-1:0], neg_r);
        lo_out <= cond_neg(step_quo, neg_q);
      end
    end
  end

  // Operand capture on acceptance, then one restoring step per BUSY cycle
  always_ff @(posedge clk) begin
    if (accept) begin
      rem     <= '0;
      quo     <= cond_neg(opa, signed_div && opa[WIDTH-1]);
      divisor <= cond_neg(opb, signed_div && opb[WIDTH-1]);
      neg_q   <= signed_div && (opa[WIDTH-1] ^ opb[WIDTH-1]);
      neg_r   <= signed_div && opa[WIDTH-1];
    end else if (state == DIV_BUSY) begin
      rem <= step_rem;
      quo <= step_quo;
    end
  end

endmodule

// File: tb/tb_div_seq.sv
// Directed bench for div_seq with a cycle-countdown reference model that is
// compared against the DUT every cycle, plus literal result/latency checks.
module tb_div_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        signed_div;
  logic [31:0] opa;
  logic [31:0] opb;
  logic        annul;
  logic        stall;
  logic        ready;
  logic        hilo_we;
  logic [31:0] hi_out;
  logic [31:0] lo_out;

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;

  div_seq #(.WIDTH(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .signed_div (signed_div),
    .opa        (opa),
    .opb        (opb),
    .annul      (annul),
    .stall      (stall),
    .ready      (ready),
    .hilo_we    (hilo_we),
    .hi_out     (hi_out),
    .lo_out     (lo_out)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got 0x%08h, expected 0x%08h", nm, cyc, act, exp);
    end
  endtask

  // Reference quotient/remainder from plain 64-bit arithmetic
  function automatic void model_div(input bit sgn, input logic [31:0] a,
                                    input logic [31:0] b,
                                    output logic [31:0] q, output logic [31:0] r);
    longint na, nb, nq, nr;
    if (b == 0) begin
      q = 0; r = 0;
    end else begin
      if (sgn) begin
        na = longint'($signed(a));
        nb = longint'($signed(b));
      end else begin
        na = longint'({32'd0, a});
        nb = longint'({32'd0, b});
      end
      nq = na / nb;
      nr = na % nb;
      q = nq[31:0];
      r = nr[31:0];
    end
  endfunction

  // Model: m_busy counts cycles still to wait, m_done marks the result cycle
  int          m_busy = 0;
  bit          m_done = 0;
  bit          mv     = 0;
  logic [31:0] m_hi = 0, m_lo = 0, m_q = 0, m_r = 0;

  always @(negedge clk) begin
    bit idle, e_stall, e_rdy;
    if (mv) begin
      idle    = (m_busy == 0) && !m_done;
      e_stall = (idle && start && !annul) || (m_busy > 0);
      e_rdy   = m_done && !annul;
      chk("stall",   {31'd0, stall},   {31'd0, e_stall});
      chk("ready",   {31'd0, ready},   {31'd0, e_rdy});
      chk("hilo_we", {31'd0, hilo_we}, {31'd0, e_rdy});
      chk("hi_out",  hi_out, m_hi);
      chk("lo_out",  lo_out, m_lo);
    end
    // advance the model to what the next edge must produce
    if (rst) begin
      m_busy = 0; m_done = 0; m_hi = 0; m_lo = 0; mv = 1;
    end else if (annul) begin
      m_busy = 0; m_done = 0;
    end else if (m_done) begin
      m_done = 0;
    end else if (m_busy > 0) begin
      m_busy--;
      if (m_busy == 0) begin
        m_done = 1; m_hi = m_r; m_lo = m_q;
      end
    end else if (start) begin
      model_div(signed_div, opa, opb, m_q, m_r);
      m_busy = (opb == 0) ? 1 : 32;
    end
  end

  task automatic begin_op(input bit sgn, input logic [31:0] a, input logic [31:0] b,
                          output int t0);
    @(posedge clk); #1;
    start = 1; signed_div = sgn; opa = a; opb = b;
    t0 = cyc;
  endtask

  // Full divide with literal expected results and latency
  task automatic run_div(input string nm, input bit sgn, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] elo,
                         input logic [31:0] ehi, input int elat);
    int t0;
    bit seen;
    begin_op(sgn, a, b, t0);
    @(posedge clk); #1;
    // operands wander after acceptance; the result must not care
    opa = $urandom; opb = $urandom; signed_div = ~sgn;
    seen = 0;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(negedge clk);
      if (hilo_we === 1'b1) seen = 1;
    end
    if (!seen) begin
      n_cmp++; n_fail++;
      $display("FAIL %s timeout: no hilo_we within 60 cycles", nm);
    end else begin
      chk({nm, "_lat"}, 32'(cyc - t0), 32'(elat));
      chk({nm, "_lo"}, lo_out, elo);
      chk({nm, "_hi"}, hi_out, ehi);
    end
    @(posedge clk); #1;
    start = 0;
  endtask

  initial begin
    int t0, np, p1, p2;
    bit chg;
    rst = 1; start = 0; signed_div = 0; opa = 0; opb = 0; annul = 0;
    repeat (3) @(posedge clk);
    #1;
    rst = 0;
    @(negedge clk);
    chk("rst_stall", {31'd0, stall}, 32'd0);
    chk("rst_hi", hi_out, 32'd0);
    chk("rst_lo", lo_out, 32'd0);

    run_div("divu_100_7",  0, 32'd100,        32'd7,          32'd14,         32'd2,          33);
    run_div("div_m7_2",    1, 32'hFFFFFFF9,   32'd2,          32'hFFFFFFFD,   32'hFFFFFFFF,   33);
    run_div("div_7_m2",    1, 32'd7,          32'hFFFFFFFE,   32'hFFFFFFFD,   32'd1,          33);
    run_div("div_min_m1",  1, 32'h80000000,   32'hFFFFFFFF,   32'h80000000,   32'd0,          33);
    run_div("divu_max_1",  0, 32'hFFFFFFFF,   32'd1,          32'hFFFFFFFF,   32'd0,          33);
    run_div("divu_big",    0, 32'hFFFFFFFF,   32'h80000000,   32'd1,          32'h7FFFFFFF,   33);
    run_div("div_5_0",     1, 32'd5,          32'd0,          32'd0,          32'd0,          2);

    // annul in the middle of a divide
    begin_op(0, 32'd1000, 32'd3, t0);
    repeat (10) @(posedge clk);
    #1;
    annul = 1; start = 0;
    @(negedge clk);
    chk("annul_mid_we", {31'd0, hilo_we}, 32'd0);
    @(posedge clk); #1;
    annul = 0;
    @(negedge clk);
    chk("annul_mid_stall", {31'd0, stall}, 32'd0);
    np = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (hilo_we) np++;
    end
    chk("annul_mid_pulses", 32'(np), 32'd0);

    // annul landing on the DONE cycle
    begin_op(0, 32'd20, 32'd4, t0);
    repeat (33) @(posedge clk);
    #1;
    annul = 1; start = 0;
    @(negedge clk);
    chk("annul_done_ready", {31'd0, ready}, 32'd0);
    chk("annul_done_we", {31'd0, hilo_we}, 32'd0);
    @(posedge clk); #1;
    annul = 0;
    repeat (3) @(posedge clk);

    // reset in the middle of a divide, then a clean divide
    begin_op(0, 32'd77, 32'd5, t0);
    repeat (20) @(posedge clk);
    #1;
    rst = 1; start = 0;
    @(posedge clk); #1;
    rst = 0;
    @(negedge clk);
    chk("rst_mid_stall", {31'd0, stall}, 32'd0);
    chk("rst_mid_ready", {31'd0, ready}, 32'd0);
    chk("rst_mid_hi", hi_out, 32'd0);
    chk("rst_mid_lo", lo_out, 32'd0);
    run_div("divu_9_3", 0, 32'd9, 32'd3, 32'd3, 32'd0, 33);

    // back-to-back with start held straight through DONE
    begin_op(0, 32'd50, 32'd6, t0);
    np = 0; p1 = 0; p2 = 0; chg = 0;
    for (int i = 0; i < 90; i++) begin
      @(negedge clk);
      if (hilo_we) begin
        np++;
        if (np == 1) begin
          p1 = cyc;
          chk("b2b_lo1", lo_out, 32'd8);
          chk("b2b_hi1", hi_out, 32'd2);
        end else begin
          p2 = cyc;
          chk("b2b_lo2", lo_out, 32'd9);
          chk("b2b_hi2", hi_out, 32'd5);
        end
      end
      @(posedge clk); #1;
      if (np == 1 && !chg) begin
        opa = 32'd77; opb = 32'd8; chg = 1;
      end
      if (np >= 2) start = 0;
    end
    chk("b2b_pulses", 32'(np), 32'd2);
    chk("b2b_spacing", 32'(p2 - p1), 32'd34);

    repeat (2) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
